// File: rtl/approx_adder_error_monitor.sv
// Sweeps every {a,b} pair into an external approximate adder and accumulates error metrics.
// Latency: done pulses 2^(2*WIDTH)+PIPE+1 cycles after start; no backpressure, start ignored unless idle.
module approx_adder_error_monitor #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [WIDTH:0]       dut_sum,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_count,
    output logic [3*WIDTH:0]     sum_ed,
    output logic [WIDTH:0]       max_ed,
    output logic [WIDTH-1:0]     worst_a,
    output logic [WIDTH-1:0]     worst_b
);

    localparam int PW = 2 * WIDTH;
    localparam logic [1:0]      DRAIN_LAST = (PIPE > 0) ? 2'(PIPE - 1) : 2'd0;
    localparam logic [PW-1:0]   PAIR_ONE   = 1;
    localparam logic [2*WIDTH:0] ERR_ONE   = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      pair_q, pair_d;
    logic [1:0]         drain_q, drain_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH:0]   err_q, err_d;
    logic [3*WIDTH:0]   sum_q, sum_d;
    logic [WIDTH:0]     max_q, max_d;
    logic [WIDTH-1:0]   worst_a_q, worst_a_d;
    logic [WIDTH-1:0]   worst_b_q, worst_b_d;

    logic               cap_vld;
    logic [WIDTH-1:0]   cap_a, cap_b;
    logic [WIDTH:0]     exact, ed;
    logic               cap_en;

    // Operands are re-timed to line up with the adder's result latency.
    generate
        if (PIPE == 0) begin : g_comb
            assign cap_vld = (state_q == S_SWEEP);
            assign cap_a   = pair_q[PW-1:WIDTH];
            assign cap_b   = pair_q[WIDTH-1:0];
        end else begin : g_chain
            logic [PIPE-1:0]  vld_q, vld_d;
            logic [WIDTH-1:0] a_q [PIPE];
            logic [WIDTH-1:0] a_d [PIPE];
            logic [WIDTH-1:0] b_q [PIPE];
            logic [WIDTH-1:0] b_d [PIPE];

            always_comb begin
                vld_d[0] = (state_q == S_SWEEP);
                a_d[0]   = pair_q[PW-1:WIDTH];
                b_d[0]   = pair_q[WIDTH-1:0];
                for (int i = 1; i < PIPE; i++) begin
                    vld_d[i] = vld_q[i-1];
                    a_d[i]   = a_q[i-1];
                    b_d[i]   = b_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < PIPE; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int i = 0; i < PIPE; i++) begin
                        a_q[i] <= a_d[i];
                        b_q[i] <= b_d[i];
                    end
                end
            end

            assign cap_vld = vld_q[PIPE-1];
            assign cap_a   = a_q[PIPE-1];
            assign cap_b   = b_q[PIPE-1];
        end
    endgenerate

    assign exact  = {1'b0, cap_a} + {1'b0, cap_b};
    assign ed     = (exact >= dut_sum) ? (exact - dut_sum) : (dut_sum - exact);
    assign cap_en = cap_vld && ((state_q == S_SWEEP) || (state_q == S_DRAIN));

    always_comb begin
        state_d   = state_q;
        pair_d    = pair_q;
        drain_d   = drain_q;
        err_d     = err_q;
        sum_d     = sum_q;
        max_d     = max_q;
        worst_a_d = worst_a_q;
        worst_b_d = worst_b_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SWEEP;
                    pair_d    = '0;
                    err_d     = '0;
                    sum_d     = '0;
                    max_d     = '0;
                    worst_a_d = '0;
                    worst_b_d = '0;
                end
            end
            S_SWEEP: begin
                if (pair_q == '1) begin
                    drain_d = 2'd0;
                    state_d = (PIPE == 0) ? S_DONE : S_DRAIN;
                end else begin
                    pair_d = pair_q + PAIR_ONE;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                pair_d  = '0;
            end
        endcase

        if (cap_en) begin
            if (ed != '0) begin
                err_d = err_q + ERR_ONE;
            end
            sum_d = sum_q + {{(2*WIDTH){1'b0}}, ed};
            // Strict compare: ties keep the earliest pair in sweep order.
            if (ed > max_q) begin
                max_d     = ed;
                worst_a_d = cap_a;
                worst_b_d = cap_b;
            end
        end

        busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pair_q    <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            worst_a_q <= '0;
            worst_b_q <= '0;
        end else begin
            state_q   <= state_d;
            pair_q    <= pair_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            worst_a_q <= worst_a_d;
            worst_b_q <= worst_b_d;
        end
    end

    assign op_a      = pair_q[PW-1:WIDTH];
    assign op_b      = pair_q[WIDTH-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;
    assign worst_a   = worst_a_q;
    assign worst_b   = worst_b_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed bench: three monitors (PIPE 0,1,2) at WIDTH=4 share start/reset, each fed by its own adder model.
module tb_approx_adder_error_monitor;

    localparam int W = 4;
    localparam int N = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [W-1:0]   op_a [3];
    logic [W-1:0]   op_b [3];
    logic [W:0]     dsum [3];
    logic           busy [3];
    logic           done [3];
    logic [2*W:0]   errc [3];
    logic [3*W:0]   sed  [3];
    logic [W:0]     med  [3];
    logic [W-1:0]   wa   [3];
    logic [W-1:0]   wb   [3];
    logic [34:0]    res  [3];
    int             done_cnt [3] = '{0, 0, 0};
    int             done_at  [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    // Adder models: 0 exact, 1 stuck at zero, 2 exact+1, 3 low two bits OR'ed with no carry out.
    function automatic logic [W:0] model(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
        case (m)
            0:       return 5'(a) + 5'(b);
            1:       return 5'd0;
            2:       return 5'(a) + 5'(b) + 5'd1;
            default: return {3'(a[3:2]) + 3'(b[3:2]), a[1:0] | b[1:0]};
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [W:0] f_now;
        logic [W:0] sr [2];
        assign f_now = model(mode, op_a[g], op_b[g]);
        always @(posedge clk) begin
            sr[0] <= f_now;
            sr[1] <= sr[0];
        end
        if (g == 0) begin : g_p0
            assign dsum[g] = f_now;
        end else begin : g_pn
            assign dsum[g] = sr[g-1];
        end
        assign res[g] = {errc[g], sed[g], med[g], wa[g], wb[g]};

        approx_adder_error_monitor #(.WIDTH(W), .PIPE(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .op_a      (op_a[g]),
            .op_b      (op_b[g]),
            .dut_sum   (dsum[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .err_count (errc[g]),
            .sum_ed    (sed[g]),
            .max_ed    (med[g]),
            .worst_a   (wa[g]),
            .worst_b   (wb[g])
        );
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                done_at[i]  <= cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, returns the edge index that sampled it, waits for the slowest monitor.
    task automatic run_sweep(output bit ok, output int k);
        int base2;
        base2 = done_cnt[2];
        start = 1'b1;
        tick();
        start = 1'b0;
        k  = cyc - 1;
        ok = 1'b0;
        for (int t = 0; t < 600 && !ok; t++) begin
            tick();
            ok = (done_cnt[2] > base2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({res[i], busy[i], done[i], op_a[i], op_b[i]} !== '0) begin
                fails++;
                $display("FAIL reset_state[%0d]: got res=%h busy=%b done=%b a=%h b=%h, want all 0",
                         i, res[i], busy[i], done[i], op_a[i], op_b[i]);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exact();
        int  base [3];
        int  k;
        bit  ok;
        mode = 0;
        for (int i = 0; i < 3; i++) base[i] = done_cnt[i];
        start = 1'b1;
        tick();
        start = 1'b0;
        k = cyc - 1;
        for (int t = 0; t < 18; t++) tick();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({busy[i], op_a[i], op_b[i]} !== {1'b1, 4'h1, 4'h2}) begin
                fails++;
                $display("FAIL exact_mid_pair[%0d]: got busy=%b a=%h b=%h, want busy=1 a=1 b=2",
                         i, busy[i], op_a[i], op_b[i]);
            end
        end
        ok = 1'b0;
        for (int t = 0; t < 600 && !ok; t++) begin
            tick();
            ok = (done_cnt[2] > base[2]);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL exact_timeout: got no done, want done within 600 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (res[i] !== 35'd0) begin
                fails++;
                $display("FAIL exact_results[%0d]: got %h, want 0", i, res[i]);
            end
            tests++;
            if (done_at[i] - k !== N + 1 + i || done_cnt[i] !== base[i] + 1) begin
                fails++;
                $display("FAIL exact_done_latency[%0d]: got %0d cycles (%0d pulses), want %0d (1)",
                         i, done_at[i] - k, done_cnt[i] - base[i], N + 1 + i);
            end
        end
    endtask

    task automatic test_stuck_zero();
        int k;
        bit ok;
        mode = 1;
        run_sweep(ok, k);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stuck_timeout: got no done, want done within 600 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (res[i] !== {9'd255, 13'd3840, 5'd30, 4'hF, 4'hF}) begin
                fails++;
                $display("FAIL stuck_results[%0d]: got err=%0d sum=%0d max=%0d a=%h b=%h, want 255 3840 30 f f",
                         i, errc[i], sed[i], med[i], wa[i], wb[i]);
            end
        end
    endtask

    task automatic test_plus_one();
        int k;
        bit ok;
        mode = 2;
        run_sweep(ok, k);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL plus1_timeout: got no done, want done within 600 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (res[i] !== {9'd256, 13'd256, 5'd1, 4'h0, 4'h0}) begin
                fails++;
                $display("FAIL plus1_results[%0d]: got err=%0d sum=%0d max=%0d a=%h b=%h, want 256 256 1 0 0",
                         i, errc[i], sed[i], med[i], wa[i], wb[i]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int base [3];
        int k;
        bit ok;
        mode = 1;
        for (int i = 0; i < 3; i++) base[i] = done_cnt[i];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 100; t++) tick();
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({res[i], busy[i], done[i], op_a[i], op_b[i]} !== '0) begin
                fails++;
                $display("FAIL midreset_state[%0d]: got res=%h busy=%b done=%b a=%h b=%h, want all 0",
                         i, res[i], busy[i], done[i], op_a[i], op_b[i]);
            end
        end
        rst_n = 1'b1;
        for (int t = 0; t < 300; t++) tick();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (done_cnt[i] !== base[i] || busy[i] !== 1'b0) begin
                fails++;
                $display("FAIL midreset_no_done[%0d]: got %0d pulses busy=%b, want 0 pulses busy=0",
                         i, done_cnt[i] - base[i], busy[i]);
            end
        end
        run_sweep(ok, k);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midreset_timeout: got no done, want done within 600 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (res[i] !== {9'd255, 13'd3840, 5'd30, 4'hF, 4'hF}) begin
                fails++;
                $display("FAIL midreset_rerun[%0d]: got err=%0d sum=%0d max=%0d, want 255 3840 30",
                         i, errc[i], sed[i], med[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int  base [3];
        int  k;
        bit  fin;
        bit  pulsed;
        logic [34:0] held [3];
        mode = 0;
        for (int i = 0; i < 3; i++) base[i] = done_cnt[i];
        start = 1'b1;
        tick();
        start = 1'b0;
        k = cyc - 1;
        for (int t = 0; t < 50; t++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        fin = 1'b0;
        pulsed = 1'b0;
        for (int t = 0; t < 600 && !fin; t++) begin
            if (done[0] && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            tick();
            start = 1'b0;
            fin = (done_cnt[2] > base[2]);
        end
        tests++;
        if (!fin || !pulsed) begin
            fails++;
            $display("FAIL ignore_timeout: got fin=%b pulsed=%b, want both 1", fin, pulsed);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (res[i] !== 35'd0 || done_at[i] - k !== N + 1 + i) begin
                fails++;
                $display("FAIL ignore_results[%0d]: got res=%h latency=%0d, want 0 and %0d",
                         i, res[i], done_at[i] - k, N + 1 + i);
            end
            held[i] = res[i];
        end
        for (int t = 0; t < 10; t++) tick();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (res[i] !== 35'd0 || busy[i] !== 1'b0 || done_cnt[i] !== base[i] + 1) begin
                fails++;
                $display("FAIL ignore_hold[%0d]: got res=%h busy=%b pulses=%0d, want %h 0 1",
                         i, res[i], busy[i], done_cnt[i] - base[i], held[i]);
            end
        end
    endtask

    task automatic test_approx_scoreboard();
        int e, s, mx, xa, xb, ex, ap, d, k;
        bit ok;
        logic [34:0] expv;
        mode = 3;
        e = 0; s = 0; mx = 0; xa = 0; xb = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ex = a + b;
                ap = (((a >> 2) + (b >> 2)) << 2) + ((a & 3) | (b & 3));
                d  = (ex > ap) ? ex - ap : ap - ex;
                if (d != 0) e++;
                s += d;
                if (d > mx) begin
                    mx = d;
                    xa = a;
                    xb = b;
                end
            end
        end
        expv = {9'(e), 13'(s), 5'(mx), 4'(xa), 4'(xb)};
        run_sweep(ok, k);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL approx_timeout: got no done, want done within 600 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (res[i] !== expv) begin
                fails++;
                $display("FAIL approx_results[%0d]: got err=%0d sum=%0d max=%0d a=%h b=%h, want %0d %0d %0d %h %h",
                         i, errc[i], sed[i], med[i], wa[i], wb[i], e, s, mx, xa, xb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_stuck_zero();
        test_plus_one();
        test_reset_mid_sweep();
        test_start_ignored();
        test_approx_scoreboard();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
